// File: rtl/divider_32.sv
// 32-bit restoring divider, signed or unsigned, one quotient bit per cycle.
// Results and flags are registered on the FIN edge and stay stable until the next FIN.
module divider_32 (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic        SIGNED,
  input  logic [31:0] DIVIDEND,
  input  logic [31:0] DIVISOR,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] QUOTIENT,
  output logic [31:0] REMAINDER,
  output logic        ZERO,
  output logic        DVZ,
  output logic        OVO,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, FIN = 2'd3} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] r_reg;
  logic [31:0] q_reg;
  logic [31:0] d_reg;
  logic        neg_q;
  logic        neg_r;
  logic        ovf;
  logic        dvz;

  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [63:0] first_step;
  logic [63:0] calc_step;

  // One restoring iteration: shift the next dividend bit into the partial
  // remainder and keep the difference only when it does not go negative.
  function automatic logic [63:0] div_step(input logic [31:0] r,
                                           input logic [31:0] q,
                                           input logic [31:0] d);
    logic [32:0] sh;
    logic [32:0] diff;
    sh   = {r, q[31]};
    diff = sh - {1'b0, d};
    if (!diff[32]) return {diff[31:0], q[30:0], 1'b1};
    else           return {sh[31:0], q[30:0], 1'b0};
  endfunction

  always_comb begin
    a_abs      = (SIGNED && DIVIDEND[31]) ? (32'd0 - DIVIDEND) : DIVIDEND;
    b_abs      = (SIGNED && DIVISOR[31])  ? (32'd0 - DIVISOR)  : DIVISOR;
    // The first iteration happens on the capture edge, so CALC needs 31 more.
    first_step = div_step(32'd0, a_abs, b_abs);
    calc_step  = div_step(r_reg, q_reg, d_reg);
  end

  assign dbg_state = state;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state     <= IDLE;
      cnt       <= 6'd0;
      r_reg     <= 32'd0;
      q_reg     <= 32'd0;
      d_reg     <= 32'd0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      ovf       <= 1'b0;
      dvz       <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      QUOTIENT  <= 32'd0;
      REMAINDER <= 32'd0;
      ZERO      <= 1'b1;
      DVZ       <= 1'b0;
      OVO       <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          BUSY <= START;
          if (START) begin
            neg_q <= SIGNED & (DIVIDEND[31] ^ DIVISOR[31]);
            neg_r <= SIGNED & DIVIDEND[31];
            ovf   <= SIGNED && (DIVIDEND == 32'h8000_0000) && (DIVISOR == 32'hFFFF_FFFF);
            d_reg <= b_abs;
            if (DIVISOR == 32'd0) begin
              dvz   <= 1'b1;
              q_reg <= 32'hFFFF_FFFF;
              r_reg <= DIVIDEND;
              state <= FIN;
            end else begin
              dvz            <= 1'b0;
              {r_reg, q_reg} <= first_step;
              cnt            <= 6'd1;
              state          <= CALC;
            end
          end
        end
        CALC: begin
          {r_reg, q_reg} <= calc_step;
          cnt            <= cnt + 6'd1;
          if (cnt == 6'd31) state <= FIX;
        end
        FIX: begin
          if (neg_q) q_reg <= 32'd0 - q_reg;
          if (neg_r) r_reg <= 32'd0 - r_reg;
          state <= FIN;
        end
        FIN: begin
          QUOTIENT  <= q_reg;
          REMAINDER <= r_reg;
          ZERO      <= (q_reg == 32'd0);
          DVZ       <= dvz;
          OVO       <= ovf;
          DONE      <= 1'b1;
          cnt       <= 6'd0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_32.sv
// Directed bench for divider_32: vector table for single operations plus
// hand-written sequences for busy-START, back-to-back START and mid-op reset.
module tb_divider_32;

  logic        CLK;
  logic        RESET;
  logic        START;
  logic        SIGNED;
  logic [31:0] DIVIDEND;
  logic [31:0] DIVISOR;
  logic        BUSY;
  logic        DONE;
  logic [31:0] QUOTIENT;
  logic [31:0] REMAINDER;
  logic        ZERO;
  logic        DVZ;
  logic        OVO;
  logic [1:0]  dbg_state;

  divider_32 dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .START     (START),
    .SIGNED    (SIGNED),
    .DIVIDEND  (DIVIDEND),
    .DIVISOR   (DIVISOR),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .QUOTIENT  (QUOTIENT),
    .REMAINDER (REMAINDER),
    .ZERO      (ZERO),
    .DVZ       (DVZ),
    .OVO       (OVO),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    logic        dvz;
    logic        ovo;
    int          lat;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs[NVEC];

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Driver: present operands and pulse START across one edge (edge N).
  task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b);
    SIGNED   = s;
    DIVIDEND = a;
    DIVISOR  = b;
    START    = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
  endtask

  // Counts edges until DONE is seen #1 after an edge; -1 when the budget expires.
  task automatic wait_done(input int max_cyc, output int lat);
    lat = -1;
    for (int k = 1; k <= max_cyc; k++) begin
      @(posedge CLK);
      #1;
      if (DONE) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge CLK);
      #1;
      if (DONE) n++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, {31'd0, BUSY}, 32'd0);
    chk({tag, "_done"}, {31'd0, DONE}, 32'd0);
    chk({tag, "_q"},    QUOTIENT,      32'd0);
    chk({tag, "_r"},    REMAINDER,     32'd0);
    chk({tag, "_zero"}, {31'd0, ZERO}, 32'd1);
    chk({tag, "_dvz"},  {31'd0, DVZ},  32'd0);
    chk({tag, "_ovo"},  {31'd0, OVO},  32'd0);
  endtask

  initial begin
    int lat;
    int n;
    string tag;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b0, 1'b0, 33};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 1'b0, 1'b0, 33};
    vecs[2]  = '{1'b0, 32'd3,          32'd5,          32'd0,          32'd3,          1'b1, 1'b0, 1'b0, 33};
    vecs[3]  = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b0, 1'b1, 1'b0, 1};
    vecs[4]  = '{1'b0, 32'd6,          32'd3,          32'd2,          32'd0,          1'b0, 1'b0, 1'b0, 33};
    vecs[5]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 1'b0, 1'b1, 33};
    vecs[6]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b1, 1'b0, 1'b0, 33};
    vecs[7]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 1'b0, 1'b0, 33};
    vecs[8]  = '{1'b1, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'd2,          32'hFFFF_FFFE,  1'b0, 1'b0, 1'b0, 33};
    vecs[9]  = '{1'b0, 32'hFFFF_FFFF,  32'd10,         32'h1999_9999,  32'd5,          1'b0, 1'b0, 1'b0, 33};
    vecs[10] = '{1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b0, 1'b1, 1'b0, 1};
    vecs[11] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 1'b0, 1'b0, 33};
    vecs[12] = '{1'b1, 32'd0,          32'hFFFF_FFFB,  32'd0,          32'd0,          1'b1, 1'b0, 1'b0, 33};

    RESET    = 1'b0;
    START    = 1'b0;
    SIGNED   = 1'b0;
    DIVIDEND = 32'd0;
    DIVISOR  = 32'd0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_outputs("reset");
    chk("reset_state", {30'd0, dbg_state}, 32'd0);
    RESET = 1'b1;
    @(posedge CLK);
    #1;

    // Table-driven single operations
    for (int i = 0; i < NVEC; i++) begin
      tag = $sformatf("v%0d", i);
      start_op(vecs[i].s, vecs[i].a, vecs[i].b);
      wait_done(40, lat);
      chk({tag, "_lat"},  lat,                   vecs[i].lat);
      chk({tag, "_q"},    QUOTIENT,              vecs[i].q);
      chk({tag, "_r"},    REMAINDER,             vecs[i].r);
      chk({tag, "_zero"}, {31'd0, ZERO},         {31'd0, vecs[i].z});
      chk({tag, "_dvz"},  {31'd0, DVZ},          {31'd0, vecs[i].dvz});
      chk({tag, "_ovo"},  {31'd0, OVO},          {31'd0, vecs[i].ovo});
      chk({tag, "_busy_at_done"}, {31'd0, BUSY}, 32'd1);
      @(posedge CLK);
      #1;
      chk({tag, "_done_pulse"}, {31'd0, DONE},   32'd0);
      chk({tag, "_busy_after"}, {31'd0, BUSY},   32'd0);
    end

    // Results hold while idle with changing inputs
    DIVIDEND = 32'h1234_5678;
    DIVISOR  = 32'd0;
    repeat (3) @(posedge CLK);
    #1;
    chk("hold_q", QUOTIENT,  32'd0);
    chk("hold_r", REMAINDER, 32'd0);

    // START pulsed at N+5 while busy is ignored
    start_op(1'b0, 32'd100, 32'd7);
    repeat (4) @(posedge CLK);
    #1;
    start_op(1'b0, 32'd9, 32'd3);
    wait_done(40, lat);
    chk("busy_start_lat", lat, 28);
    chk("busy_start_q",   QUOTIENT,  32'd14);
    chk("busy_start_r",   REMAINDER, 32'd2);
    count_dones(40, n);
    chk("busy_start_no_extra_done", n, 0);

    // START held high through DONE launches the next operation right after FIN
    SIGNED   = 1'b0;
    DIVIDEND = 32'd100;
    DIVISOR  = 32'd7;
    START    = 1'b1;
    @(posedge CLK);
    #1;
    wait_done(40, lat);
    chk("held_first_lat", lat, 33);
    chk("held_first_q",   QUOTIENT, 32'd14);
    DIVIDEND = 32'd6;
    DIVISOR  = 32'd3;
    @(posedge CLK);
    #1 START = 1'b0;
    chk("held_second_busy", {31'd0, BUSY}, 32'd1);
    wait_done(40, lat);
    chk("held_second_lat", lat, 33);
    chk("held_second_q",   QUOTIENT,  32'd2);
    chk("held_second_r",   REMAINDER, 32'd0);
    @(posedge CLK);
    #1;

    // Reset at N+10 abandons the operation
    start_op(1'b0, 32'd100, 32'd7);
    repeat (9) @(posedge CLK);
    #1 RESET = 1'b0;
    @(posedge CLK);
    #1;
    check_reset_outputs("midreset");
    RESET = 1'b1;
    count_dones(40, n);
    chk("midreset_no_done", n, 0);
    start_op(1'b0, 32'd9, 32'd3);
    wait_done(40, lat);
    chk("after_reset_lat", lat, 33);
    chk("after_reset_q",   QUOTIENT,  32'd3);
    chk("after_reset_r",   REMAINDER, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
